instr_fetch_unit: RTL and testbench

//   Front end of the core: fetches 32-bit instructions from instruction memory and presents

---
 rtl/instr_fetch_unit_if.sv | 47 ++++
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Bus interfaces for instr_fetch_unit.
//   ifu_imem_if : fetch request/response channel toward instruction memory
//   ifu_dec_if  : instruction hand-off channel toward the main decoder
// In both, the master modport is the fetch unit's side.

interface ifu_imem_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata
    );
endinterface

interface ifu_dec_if #(
    parameter int XLEN = 32
);
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    logic [XLEN-1:0] instr_pc_plus4;
    logic            instr_valid;
    logic            instr_ready;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic            fetch_fault;

    modport master (
        output instr, instr_pc, instr_pc_plus4, instr_valid, fetch_fault,
        input  instr_ready, redirect, redirect_target
    );

    modport slave (
        input  instr, instr_pc, instr_pc_plus4, instr_valid, fetch_fault,
        output instr_ready, redirect, redirect_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: core front end. Fetches one 32-bit instruction at a time from
// instruction memory, holds it in a single output register toward decode, and
// takes the decoder's PCSrc (redirect) as the next-PC select when that
// instruction retires.
// Optional feature macro: IFU_MISALIGN_CHECK_EN -- a redirect to a non
// word-aligned target stops fetching and raises a sticky fetch_fault.
// Without it the low two target bits are dropped and fetch_fault is tied 0.

module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    ifu_imem_if.master imem,
    ifu_dec_if.master  dec
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
`ifdef IFU_MISALIGN_CHECK_EN
        ,
        S_FAULT
`endif
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic            req_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic [XLEN-1:0] pc_plus4_q;
    logic            valid_q;
`ifdef IFU_MISALIGN_CHECK_EN
    logic            fault_q;
`endif

    // Next fetch address at retire: taken target (forced to a word boundary)
    // or the sequential successor. Addition wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] next_pc(
        input logic            redir,
        input logic [XLEN-1:0] target,
        input logic [XLEN-1:0] seq
    );
        return redir ? (target & ~XLEN'(3)) : seq;
    endfunction

    // Fetch FSM: request -> wait for data -> hold for decode -> next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            instr_q    <= NOP;
            instr_pc_q <= RESET_PC;
            pc_plus4_q <= RESET_PC + XLEN'(4);
            valid_q    <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_REQ;
                    req_q <= 1'b1;
                end
                S_REQ: begin
                    // Address is held in pc_q, so it stays stable until accepted.
                    if (imem.imem_ready) begin
                        state <= S_WAIT;
                        req_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        state      <= S_HOLD;
                        instr_q    <= imem.imem_rdata;
                        instr_pc_q <= pc_q;
                        pc_plus4_q <= pc_q + XLEN'(4);
                        valid_q    <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (dec.instr_ready) begin
                        valid_q <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
                        if (dec.redirect && (dec.redirect_target[1:0] != 2'b00)) begin
                            state   <= S_FAULT;
                            fault_q <= 1'b1;
                        end else
`endif
                        begin
                            state <= S_REQ;
                            req_q <= 1'b1;
                            pc_q  <= next_pc(dec.redirect, dec.redirect_target, pc_plus4_q);
                        end
                    end
                end
`ifdef IFU_MISALIGN_CHECK_EN
                S_FAULT: begin
                    // Sticky until reset: no requests, nothing presented to decode.
                    state <= S_FAULT;
                end
`endif
                default: begin
                    state   <= S_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req      = req_q;
    assign imem.imem_addr     = pc_q;
    assign dec.instr          = instr_q;
    assign dec.instr_pc       = instr_pc_q;
    assign dec.instr_pc_plus4 = pc_plus4_q;
    assign dec.instr_valid    = valid_q;
`ifdef IFU_MISALIGN_CHECK_EN
    assign dec.fetch_fault    = fault_q;
`else
    assign dec.fetch_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: drives the memory and decode sides
// by hand from one initial block and checks outputs on the falling edge.

module tb_instr_fetch_unit;

    logic clk;
    logic rst_n;

    ifu_imem_if #(.XLEN(32)) imem ();
    ifu_dec_if  #(.XLEN(32)) dec ();

    instr_fetch_unit #(
        .XLEN    (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .imem (imem.master),
        .dec  (dec.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] cur_data;
    logic [31:0] cur_pc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for a request at addr, accept it after rwait stalled cycles, return
    // data one cycle later and check the presented instruction. With noise set,
    // redirect/instr_ready are toggled while nothing is valid.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                         input int rwait, input bit noise);
        int n = 0;
        logic [31:0] p4;
        p4 = addr + 32'd4;
        while (imem.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", imem.imem_req, 1);
        check("imem_addr", imem.imem_addr, addr);
        check("valid_in_req", dec.instr_valid, 0);
        if (noise) begin
            dec.instr_ready     = 1'b1;
            dec.redirect        = 1'b1;
            dec.redirect_target = 32'h0000_0080;
        end
        for (int i = 0; i < rwait; i++) begin
            imem.imem_ready = 1'b0;
            @(negedge clk);
            check("addr_stable", imem.imem_addr, addr);
            check("req_stable", imem.imem_req, 1);
        end
        imem.imem_ready = 1'b1;
        @(negedge clk);
        imem.imem_ready = 1'b0;
        check("req_in_wait", imem.imem_req, 0);
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = data;
        @(negedge clk);
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'hDEAD_BEEF;
        if (noise) begin
            dec.instr_ready     = 1'b0;
            dec.redirect        = 1'b0;
            dec.redirect_target = 32'h0;
        end
        check("instr_valid", dec.instr_valid, 1);
        check("instr", dec.instr, data);
        check("instr_pc", dec.instr_pc, addr);
        check("instr_pc_plus4", dec.instr_pc_plus4, p4);
        cur_data = data;
        cur_pc   = addr;
    endtask

    // Hold the instruction for hold cycles, then retire it with the given redirect.
    task automatic retire(input bit redir, input logic [31:0] tgt, input int hold,
                          input bit exp_req);
        for (int i = 0; i < hold; i++) begin
            dec.instr_ready = 1'b0;
            check("hold_valid", dec.instr_valid, 1);
            check("hold_instr", dec.instr, cur_data);
            check("hold_pc", dec.instr_pc, cur_pc);
            check("hold_no_req", imem.imem_req, 0);
            @(negedge clk);
        end
        dec.instr_ready     = 1'b1;
        dec.redirect        = redir;
        dec.redirect_target = tgt;
        @(negedge clk);
        dec.instr_ready     = 1'b0;
        dec.redirect        = 1'b0;
        dec.redirect_target = 32'h0;
        check("valid_after_retire", dec.instr_valid, 0);
        check("req_after_retire", imem.imem_req, exp_req);
    endtask

    initial begin
        imem.imem_ready     = 1'b0;
        imem.imem_rvalid    = 1'b0;
        imem.imem_rdata     = 32'h0;
        dec.instr_ready     = 1'b0;
        dec.redirect        = 1'b0;
        dec.redirect_target = 32'h0;
        cur_data            = 32'h0;
        cur_pc              = 32'h0;
        rst_n               = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset values
        check("rst_req", imem.imem_req, 0);
        check("rst_addr", imem.imem_addr, 32'h0);
        check("rst_instr", dec.instr, 32'h0000_0013);
        check("rst_instr_pc", dec.instr_pc, 32'h0);
        check("rst_valid", dec.instr_valid, 0);
        check("rst_fault", dec.fetch_fault, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // First fetch and sequential stream 0x0, 0x4, 0x8, 0xC
        fetch(32'h0000_0000, 32'h0000_0093, 0, 1'b0);
        retire(1'b0, 32'h0, 0, 1'b1);
        fetch(32'h0000_0004, 32'h0010_0113, 0, 1'b0);
        retire(1'b0, 32'h0, 0, 1'b1);
        fetch(32'h0000_0008, 32'h0020_0193, 0, 1'b0);
        retire(1'b0, 32'h0, 0, 1'b1);
        fetch(32'h0000_000C, 32'h0030_0213, 0, 1'b0);
        retire(1'b0, 32'h0, 0, 1'b1);

        // Taken branch at 0x10 to 0x40
        fetch(32'h0000_0010, 32'h0220_8863, 0, 1'b0);
        retire(1'b1, 32'h0000_0040, 0, 1'b1);
        fetch(32'h0000_0040, 32'h0000_0013, 0, 1'b0);
        retire(1'b1, 32'h0000_0010, 0, 1'b1);
        fetch(32'h0000_0010, 32'h0220_8863, 0, 1'b0);
        retire(1'b0, 32'h0, 0, 1'b1);

        // Redirect pulsed while nothing is valid: ignored, fetch stays at 0x14
        fetch(32'h0000_0014, 32'h0000_0513, 2, 1'b1);

        // Backpressure on both sides
        retire(1'b0, 32'h0, 7, 1'b1);
        fetch(32'h0000_0018, 32'h0050_0593, 5, 1'b0);
        retire(1'b0, 32'h0, 7, 1'b1);

        // Reset while waiting for data at 0x1C; late response must be dropped
        check("req_1c", imem.imem_req, 1);
        check("addr_1c", imem.imem_addr, 32'h0000_001C);
        imem.imem_ready = 1'b1;
        @(negedge clk);
        imem.imem_ready = 1'b0;
        check("wait_1c_no_req", imem.imem_req, 0);
        rst_n            = 1'b0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'h0BAD_0BAD;
        #1;
        check("async_rst_req", imem.imem_req, 0);
        check("async_rst_addr", imem.imem_addr, 32'h0);
        check("async_rst_valid", dec.instr_valid, 0);
        check("async_rst_instr", dec.instr, 32'h0000_0013);
        @(negedge clk);
        check("rst_hold_valid", dec.instr_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("stale_rvalid_valid", dec.instr_valid, 0);
        check("restart_req", imem.imem_req, 1);
        imem.imem_rvalid = 1'b0;
        fetch(32'h0000_0000, 32'h0000_0093, 0, 1'b0);

        // PC wrap from 0xFFFF_FFFC
        retire(1'b1, 32'hFFFF_FFFC, 0, 1'b1);
        fetch(32'hFFFF_FFFC, 32'h0000_006F, 0, 1'b0);
        retire(1'b0, 32'h0, 0, 1'b1);
        fetch(32'h0000_0000, 32'h0000_0093, 0, 1'b0);

        // Misaligned redirect target 0x42
`ifdef IFU_MISALIGN_CHECK_EN
        retire(1'b1, 32'h0000_0042, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("fault_set", dec.fetch_fault, 1);
            check("fault_no_req", imem.imem_req, 0);
            check("fault_no_valid", dec.instr_valid, 0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("fault_cleared", dec.fetch_fault, 0);
        rst_n = 1'b1;
        @(negedge clk);
        fetch(32'h0000_0000, 32'h0000_0093, 0, 1'b0);
`else
        retire(1'b1, 32'h0000_0042, 0, 1'b1);
        check("no_fault", dec.fetch_fault, 0);
        fetch(32'h0000_0040, 32'h0000_0013, 0, 1'b0);
        check("no_fault_after", dec.fetch_fault, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
